// File: rtl/verify_checksum.sv
// Receive-side FIX checksum verifier: sums message bytes mod 256, finds the
// <SOH>10= trailer, parses three ASCII digits and reports pass/fail/format error.
module verify_checksum #(
    parameter logic [7:0] SOH_CHAR = 8'h01
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    input  logic       start_i,
    output logic       done_o,
    output logic       ok_o,
    output logic       err_fmt_o,
    output logic [7:0] computed_o,
    output logic [7:0] received_o
);

    // D1..TERM are consecutive so the digit states can advance by increment.
    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_BODY = 4'd1;
    localparam logic [3:0] ST_TAG1 = 4'd2;
    localparam logic [3:0] ST_TAG0 = 4'd3;
    localparam logic [3:0] ST_EQ   = 4'd4;
    localparam logic [3:0] ST_D1   = 4'd5;
    localparam logic [3:0] ST_D2   = 4'd6;
    localparam logic [3:0] ST_D3   = 4'd7;
    localparam logic [3:0] ST_TERM = 4'd8;

    logic [3:0] state_q, state_d;
    logic [7:0] sum_q, sum_d;
    logic [7:0] snap_q, snap_d;
    logic [9:0] val_q, val_d;
    logic       fmt_err_q, fmt_err_d;
    logic       done_q, done_d;
    logic       ok_q, ok_d;
    logic       err_fmt_q, err_fmt_d;
    logic [7:0] computed_q, computed_d;
    logic [7:0] received_q, received_d;

    logic       is_soh_s;
    logic       is_digit_s;
    logic [7:0] digit_s;
    logic [7:0] sum_add_s;
    logic       term_err_s;

    function automatic logic ascii_digit(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    assign is_soh_s   = (data_i == SOH_CHAR);
    assign is_digit_s = ascii_digit(data_i);
    assign digit_s    = data_i - 8'h30;
    assign sum_add_s  = sum_q + data_i;
    assign term_err_s = fmt_err_q | (val_q > 10'd255) | ~is_soh_s;

    // Next-state and result computation for one accepted byte.
    always_comb begin
        state_d    = state_q;
        sum_d      = sum_q;
        snap_d     = snap_q;
        val_d      = val_q;
        fmt_err_d  = fmt_err_q;
        done_d     = 1'b0;
        ok_d       = ok_q;
        err_fmt_d  = err_fmt_q;
        computed_d = computed_q;
        received_d = received_q;
        if (valid_i && start_i) begin
            // A start byte always begins a fresh message, aborting any in flight.
            sum_d     = data_i;
            val_d     = 10'd0;
            fmt_err_d = 1'b0;
            state_d   = ST_BODY;
        end else if (valid_i) begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_BODY, ST_TAG1, ST_TAG0: begin
                    sum_d = sum_add_s;
                    if (is_soh_s) begin
                        snap_d  = sum_add_s;
                        state_d = ST_TAG1;
                    end else if ((state_q == ST_TAG1) && (data_i == 8'h31)) begin
                        state_d = ST_TAG0;
                    end else if ((state_q == ST_TAG0) && (data_i == 8'h30)) begin
                        state_d = ST_EQ;
                    end else begin
                        state_d = ST_BODY;
                    end
                end
                ST_EQ: begin
                    sum_d = sum_add_s;
                    if (data_i == 8'h3D) begin
                        val_d     = 10'd0;
                        fmt_err_d = 1'b0;
                        state_d   = ST_D1;
                    end else begin
                        state_d = ST_BODY;
                    end
                end
                ST_D1, ST_D2, ST_D3: begin
                    if (is_digit_s) begin
                        val_d = val_q * 10'd10 + {2'b00, digit_s};
                    end else begin
                        fmt_err_d = 1'b1;
                    end
                    state_d = state_q + 4'd1;
                end
                ST_TERM: begin
                    done_d     = 1'b1;
                    computed_d = snap_q;
                    received_d = val_q[7:0];
                    err_fmt_d  = term_err_s;
                    ok_d       = ~term_err_s & (val_q == {2'b00, snap_q});
                    fmt_err_d  = term_err_s;
                    state_d    = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sum_q      <= 8'h00;
            snap_q     <= 8'h00;
            val_q      <= 10'd0;
            fmt_err_q  <= 1'b0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            err_fmt_q  <= 1'b0;
            computed_q <= 8'h00;
            received_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            sum_q      <= sum_d;
            snap_q     <= snap_d;
            val_q      <= val_d;
            fmt_err_q  <= fmt_err_d;
            done_q     <= done_d;
            ok_q       <= ok_d;
            err_fmt_q  <= err_fmt_d;
            computed_q <= computed_d;
            received_q <= received_d;
        end
    end

    assign done_o     = done_q;
    assign ok_o       = ok_q;
    assign err_fmt_o  = err_fmt_q;
    assign computed_o = computed_q;
    assign received_o = received_q;

endmodule

// File: doc/verify_checksum.md
# verify_checksum

Receive-side FIX checksum verifier. It streams every byte of an incoming FIX message, keeps a modulo-256 running sum, and locates the `<SOH>10=` trailer. It parses the three ASCII checksum digits and reports pass, fail or format error one cycle after the terminating SOH. It sits beside the parser on the inbound byte stream and is the checking counterpart of the outbound checksum generator.

## Interface
- SOH_CHAR, 8'h01, field delimiter byte (benches may set 8'h7C `|`).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- data_i  in  8  message byte.
- valid_i  in  1  data_i is sampled at this posedge.
- start_i  in  1  qualified by valid_i; marks the first byte of a message, which is included in the sum.
- done_o  out  1  one-cycle pulse: verification result is valid.
- ok_o  out  1  with done_o: received value equals computed value and there is no format error.
- err_fmt_o  out  1  with done_o: malformed trailer.
- computed_o  out  8  sum mod 256 through the SOH preceding `10=`; held until the next done_o.
- received_o  out  8  parsed checksum value (low 8 bits); held until the next done_o.

## Operation
- States: IDLE, BODY, TAG1, TAG0, EQ, D1, D2, D3, TERM.
- Registers:
  - sum[7:0] is the running sum.
  - snap[7:0] is the sum captured at the last SOH.
  - val[9:0] accumulates digits as val*10 + (byte - 8'h30).
  - fmt_err is a sticky flag for the current trailer.
- Every accepted byte from the message start up to and including the SOH before `10=` is added to sum, 8-bit wrapping.
- On an accepted SOH_CHAR byte in BODY, TAG1 or TAG0: snap <= sum + byte, then go to TAG1.
  - Tag 10 is matched only directly after a SOH, so `110=` is not a match.
- IDLE: on valid_i & start_i, set sum <= data_i and go to BODY. Bytes without start_i are ignored.
- TAG1: `1` goes to TAG0; any other byte goes to BODY, with the byte added to sum and SOH handled as above.
- TAG0: `0` goes to EQ; otherwise behave as in TAG1.
- EQ: `=` goes to D1 with val <= 0; otherwise go to BODY.
- D1, D2, D3: each accepted byte in 0x30..0x39 accumulates into val.
  - A non-digit sets fmt_err and still advances.
  - Sum bytes after the trailer start are not added.
- TERM: the next accepted byte completes the trailer.
  - If the byte is not SOH_CHAR, set fmt_err.
  - If val > 255, set fmt_err.
  - Registered results: computed_o <= snap, received_o <= val[7:0], err_fmt_o <= fmt_err | val>255 | byte≠SOH, ok_o <= !err & (val == snap), done_o <= 1.
  - Then go to IDLE.
- A start_i accepted in any non-IDLE state aborts the current message with no done_o. That byte starts a new message: sum <= data_i, state BODY.
- A message with no trailer stays in BODY or TAG* indefinitely. It is discarded on the next start_i.

## Timing
- Reset values:
  - done_o, ok_o, err_fmt_o = 0.
  - computed_o, received_o = 8'h00.
  - State IDLE.
  - sum, snap, val, fmt_err = 0.
- Reset is asynchronous. Asserting rst mid-message clears all state immediately, and no done_o is produced for the interrupted message.
- One byte per cycle maximum. valid_i low stalls with all state held, including inside the trailer.
- done_o goes high exactly one cycle after the posedge at which the terminating byte is sampled, and lasts one cycle.
- ok_o and err_fmt_o are meaningful only while done_o is high. They hold their last value otherwise.
- Back-to-back messages: a start_i byte in the cycle right after the terminator is accepted. done_o for the previous message pulses in that same cycle.

## Test plan
- SOH=0x01. Stream `8=A`,SOH,`10=183`,SOH (sum 56+61+65+1 = 183) -> done_o pulse one cycle after the last SOH, ok_o=1, err_fmt_o=0, computed_o=0xB7, received_o=0xB7.
- Same body with trailer `10=184`,SOH -> ok_o=0, err_fmt_o=0, computed_o=183, received_o=184.
- Wrap-around and false tag:
  - `8=AAAA`,SOH,`10=122`,SOH (378 mod 256 = 122) -> ok_o=1.
  - `8=A`,SOH,`110=5`,SOH,`10=188`,SOH -> ok_o=1, computed_o=188.
- Format errors, each with err_fmt_o=1 and ok_o=0:
  - `10=1X3`,SOH.
  - `10=300`,SOH.
  - `10=183` followed by 0x41 instead of SOH.
- Abort and reset:
  - start_i asserted after `8=` of message 1, then valid message 2 `8=A`,SOH,`10=183`,SOH -> exactly one done_o, ok_o=1.
  - rst pulsed asynchronously after `8=A`,SOH,`1` -> outputs go to 0 immediately, no done_o; the next valid message passes.
- Stalls: the passing message from the first scenario with valid_i deasserted on random cycles, including between digits -> identical result, with done_o one cycle after the terminating SOH is sampled.
